// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared BCD types, digit limits and clamp helper for the timer.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t BCD_MAX_UNITS    = 4'd9;
   localparam bcd_t BCD_MAX_SEC_TENS = 4'd5;

   function automatic bcd_t bcd_clamp(input bcd_t i_val, input bcd_t i_max);
      return (i_val > i_max) ? i_max : i_val;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_digit
// Brief    : One loadable BCD down-counting digit that wraps to MAX on borrow.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_digit
   import timer_pkg::*;
#(
   parameter bcd_t MAX = BCD_MAX_UNITS
) (
   input  logic clock_100Hz,
   input  logic clearn,
   input  logic load,
   input  bcd_t load_val,
   input  logic dec,
   output bcd_t q,
   output logic borrow_out
);

   bcd_t r_q;

   always_ff @(posedge clock_100Hz or negedge clearn) begin
      if (!clearn) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= load_val;
      end else if (dec) begin
         r_q <= (r_q == '0) ? MAX : r_q - bcd_t'(1);
      end
   end

   assign q          = r_q;
   assign borrow_out = dec & (r_q == '0);

endmodule
`default_nettype wire

// File: rtl/timer_countdown_module.sv
`default_nettype none
// ============================================================================
// Module   : timer_countdown_module
// Brief    : M:SS BCD countdown timer with keyed digit entry and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module timer_countdown_module
   import timer_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock_100Hz,
   input  logic       clearn,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       countdown_en,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] mins,
   output logic       zero,
   output logic       done
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   r_done;

   logic w_tick;
   logic w_load;
   logic w_count;
   logic w_last_sec;
   logic w_ones_borrow;
   logic w_tens_borrow;
   logic w_mins_borrow;

   always_ff @(posedge clock_100Hz or negedge clearn) begin
      if (!clearn) begin
         r_sync <= '0;
         r_hist <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pgt_1Hz};
         r_hist <= r_sync[SYNC_STAGES-1];
         // Counting is blocked at 0:00, so the minutes borrow never fires here;
         // done only ever marks the step from 0:01 down to 0:00.
         r_done <= w_count & w_last_sec & ~w_mins_borrow;
      end
   end

   assign w_tick     = r_sync[SYNC_STAGES-1] & ~r_hist;
   assign w_load     = w_tick & ~loadn;
   assign w_count    = w_tick & loadn & countdown_en & ~zero;
   assign w_last_sec = (mins == '0) && (sec_tens == '0) && (sec_ones == 4'd1);

   bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_sec_ones (
      .clock_100Hz (clock_100Hz),
      .clearn      (clearn),
      .load        (w_load),
      .load_val    (bcd_clamp(D, BCD_MAX_UNITS)),
      .dec         (w_count),
      .q           (sec_ones),
      .borrow_out  (w_ones_borrow)
   );

   bcd_down_digit #(.MAX(BCD_MAX_SEC_TENS)) u_sec_tens (
      .clock_100Hz (clock_100Hz),
      .clearn      (clearn),
      .load        (w_load),
      .load_val    (bcd_clamp(sec_ones, BCD_MAX_SEC_TENS)),
      .dec         (w_ones_borrow),
      .q           (sec_tens),
      .borrow_out  (w_tens_borrow)
   );

   bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_mins (
      .clock_100Hz (clock_100Hz),
      .clearn      (clearn),
      .load        (w_load),
      .load_val    (sec_tens),
      .dec         (w_tens_borrow),
      .q           (mins),
      .borrow_out  (w_mins_borrow)
   );

   assign zero = (mins == '0) && (sec_tens == '0) && (sec_ones == '0);
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_timer_countdown_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_countdown_module
// Brief    : Directed scoreboard bench for the BCD countdown timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_countdown_module;

   localparam int SYNC = 2;

   typedef struct {
      string       tag;
      logic [13:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       clearn;
   logic [3:0] D;
   logic       loadn;
   logic       pgt;
   logic       en;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] mins;
   logic       zero;
   logic       done;

   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   logic [3:0] cur_m = 4'd0;
   logic [3:0] cur_t = 4'd0;
   logic [3:0] cur_o = 4'd0;

   timer_countdown_module #(.SYNC_STAGES(SYNC)) dut (
      .clock_100Hz  (clk),
      .clearn       (clearn),
      .D            (D),
      .loadn        (loadn),
      .pgt_1Hz      (pgt),
      .countdown_en (en),
      .sec_ones     (sec_ones),
      .sec_tens     (sec_tens),
      .mins         (mins),
      .zero         (zero),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] o, input logic d);
      exp_t e;
      logic z;
      z     = (m == 4'd0) && (t == 4'd0) && (o == 4'd0);
      e.tag = tag;
      e.val = {m, t, o, z, d};
      sb.push_back(e);
   endtask

   task automatic check_next();
      exp_t        e;
      logic [13:0] obs;
      e   = sb.pop_front();
      obs = {mins, sec_tens, sec_ones, zero, done};
      checks++;
      assert (obs === e.val) else begin
         failures++;
         $error("FAIL %s observed m:to=%h:%h%h z=%b d=%b expected m:to=%h:%h%h z=%b d=%b",
                e.tag, obs[13:10], obs[9:6], obs[5:2], obs[1], obs[0],
                e.val[13:10], e.val[9:6], e.val[5:2], e.val[1], e.val[0]);
      end
   endtask

   // One strobe: digits must hold for SYNC edges, then change with the given done.
   task automatic tick(input string tag, input logic [3:0] d_in, input logic [3:0] m,
                       input logic [3:0] t, input logic [3:0] o, input logic dn);
      @(negedge clk);
      D   = d_in;
      pgt = 1'b1;
      for (int i = 0; i < SYNC; i++) begin
         @(negedge clk);
         push({tag, "_hold"}, cur_m, cur_t, cur_o, 1'b0);
         check_next();
      end
      @(negedge clk);
      push(tag, m, t, o, dn);
      check_next();
      pgt = 1'b0;
      repeat (SYNC) @(negedge clk);
      push({tag, "_after"}, m, t, o, 1'b0);
      check_next();
      cur_m = m;
      cur_t = t;
      cur_o = o;
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge clk);
      #2 clearn = 1'b0;
      #1 push(tag, 4'd0, 4'd0, 4'd0, 1'b0);
      check_next();
      @(negedge clk);
      clearn = 1'b1;
      cur_m = 4'd0;
      cur_t = 4'd0;
      cur_o = 4'd0;
   endtask

   initial begin
      clearn = 1'b0;
      D      = 4'd0;
      loadn  = 1'b0;
      pgt    = 1'b0;
      en     = 1'b0;
      #3 push("reset_init", 4'd0, 4'd0, 4'd0, 1'b0);
      check_next();
      @(negedge clk);
      clearn = 1'b1;

      tick("entry_1", 4'd1, 4'd0, 4'd0, 4'd1, 1'b0);
      tick("entry_13", 4'd3, 4'd0, 4'd1, 4'd3, 1'b0);
      tick("entry_130", 4'd0, 4'd1, 4'd3, 4'd0, 1'b0);
      loadn = 1'b1;
      en    = 1'b1;
      tick("count_129", 4'd0, 4'd1, 4'd2, 4'd9, 1'b0);

      reset_pulse("reset_a");
      loadn = 1'b0;
      tick("entry_1b", 4'd1, 4'd0, 4'd0, 4'd1, 1'b0);
      tick("entry_10", 4'd0, 4'd0, 4'd1, 4'd0, 1'b0);
      tick("entry_100", 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
      loadn = 1'b1;
      tick("count_059", 4'd0, 4'd0, 4'd5, 4'd9, 1'b0);

      reset_pulse("reset_b");
      loadn = 1'b0;
      tick("entry_7", 4'd7, 4'd0, 4'd0, 4'd7, 1'b0);
      tick("entry_clamp52", 4'd2, 4'd0, 4'd5, 4'd2, 1'b0);

      reset_pulse("reset_c");
      tick("entry_zero_nodone", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
      tick("entry_2", 4'd2, 4'd0, 4'd0, 4'd2, 1'b0);
      loadn = 1'b1;
      tick("count_001", 4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
      tick("count_done", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
      tick("zero_hold1", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
      tick("zero_hold2", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

      reset_pulse("reset_d");
      loadn = 1'b0;
      tick("entry_4", 4'd4, 4'd0, 4'd0, 4'd4, 1'b0);
      tick("entry_45", 4'd5, 4'd0, 4'd4, 4'd5, 1'b0);
      loadn = 1'b1;
      en    = 1'b0;
      tick("pause1", 4'd0, 4'd0, 4'd4, 4'd5, 1'b0);
      tick("pause2", 4'd0, 4'd0, 4'd4, 4'd5, 1'b0);
      tick("pause3", 4'd0, 4'd0, 4'd4, 4'd5, 1'b0);
      en = 1'b1;
      tick("resume_044", 4'd0, 4'd0, 4'd4, 4'd4, 1'b0);

      reset_pulse("reset_e");
      loadn = 1'b0;
      tick("entry_3", 4'd3, 4'd0, 4'd0, 4'd3, 1'b0);
      tick("entry_30", 4'd0, 4'd0, 4'd3, 4'd0, 1'b0);
      loadn = 1'b1;
      repeat (3) @(negedge clk);
      reset_pulse("reset_midcount");
      loadn = 1'b0;
      tick("entry_5_after_reset", 4'd5, 4'd0, 4'd0, 4'd5, 1'b0);

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
